// File: rtl/ide_reset_if.sv
// IDE RESET- receiver bundle: pin-side inputs and drive-core / status-side outputs.
// master = host/pin side that drives RESET- and SRST; slave = the reset detector.
interface ide_reset_if;
    logic       ide_rst_n;
    logic       srst;
    logic       dev_rst;
    logic       rst_event;
    logic       rst_done;
    logic       bsy;
    logic       rst_soft;
    logic [7:0] glitch_cnt;

    modport master (
        output ide_rst_n,
        output srst,
        input  dev_rst,
        input  rst_event,
        input  rst_done,
        input  bsy,
        input  rst_soft,
        input  glitch_cnt
    );

    modport slave (
        input  ide_rst_n,
        input  srst,
        output dev_rst,
        output rst_event,
        output rst_done,
        output bsy,
        output rst_soft,
        output glitch_cnt
    );
endinterface

// File: rtl/ide_reset_detector.sv
// IDE RESET- receiver: synchronise, qualify minimum low time, hold the core, report BSY.
// Optional soft reset from the Device Control SRST bit: define IDE_RESET_DETECTOR_SRST_EN.
module ide_reset_detector #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [20:0] MIN_ASSERT  = 21'h000300,
    parameter logic [20:0] RECOVERY    = 21'h000400
) (
    input  logic        clk,
    input  logic        rst,
    ide_reset_if.slave  bus
);

    localparam logic [20:0] QUAL_LAST = MIN_ASSERT - 21'd1;
    localparam logic [20:0] REC_LAST  = RECOVERY - 21'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        HELD    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    // Synchroniser chain; resets to the released (high) level.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = bus.ide_rst_n;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_next;
        end
    end

    logic l_sync;
    assign l_sync = sync_reg[SYNC_STAGES-1];

    state_t      state_reg,      state_next;
    logic [20:0] cnt_reg,        cnt_next;
    logic        from_rec_reg,   from_rec_next;
    logic        dev_rst_reg,    dev_rst_next;
    logic        bsy_reg,        bsy_next;
    logic        rst_event_reg,  rst_event_next;
    logic        rst_done_reg,   rst_done_next;
    logic        rst_soft_reg,   rst_soft_next;
    logic [7:0]  glitch_cnt_reg, glitch_cnt_next;

    logic qual_hit;
    logic rec_hit;
    logic srst_clear;
    assign qual_hit = (cnt_reg == QUAL_LAST);
    assign rec_hit  = (cnt_reg == REC_LAST);

`ifdef IDE_RESET_DETECTOR_SRST_EN
    // Previous SRST tracks through rst so a level already high at release is not an edge.
    logic srst_prev_reg;
    logic soft_edge;

    always_ff @(posedge clk) begin
        srst_prev_reg <= bus.srst;
    end

    assign soft_edge  = bus.srst & ~srst_prev_reg;
    assign srst_clear = ~bus.srst;
`else
    assign srst_clear = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            from_rec_reg   <= 1'b0;
            dev_rst_reg    <= 1'b0;
            bsy_reg        <= 1'b0;
            rst_event_reg  <= 1'b0;
            rst_done_reg   <= 1'b0;
            rst_soft_reg   <= 1'b0;
            glitch_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            from_rec_reg   <= from_rec_next;
            dev_rst_reg    <= dev_rst_next;
            bsy_reg        <= bsy_next;
            rst_event_reg  <= rst_event_next;
            rst_done_reg   <= rst_done_next;
            rst_soft_reg   <= rst_soft_next;
            glitch_cnt_reg <= glitch_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        from_rec_next   = from_rec_reg;
        dev_rst_next    = dev_rst_reg;
        bsy_next        = bsy_reg;
        rst_event_next  = 1'b0;
        rst_done_next   = 1'b0;
        rst_soft_next   = rst_soft_reg;
        glitch_cnt_next = glitch_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (!l_sync) begin
                    state_next    = QUALIFY;
                    cnt_next      = '0;
                    from_rec_next = 1'b0;
                end
            end

            QUALIFY: begin
                if (!l_sync) begin
                    if (qual_hit) begin
                        state_next     = HELD;
                        cnt_next       = '0;
                        dev_rst_next   = 1'b1;
                        bsy_next       = 1'b1;
                        rst_event_next = 1'b1;
                        rst_soft_next  = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + 21'd1;
                    end
                end else begin
                    // Short pulse rejected; recovery restarts from zero if it was interrupted.
                    if (glitch_cnt_reg != 8'hFF) begin
                        glitch_cnt_next = glitch_cnt_reg + 8'd1;
                    end
                    cnt_next   = '0;
                    state_next = from_rec_reg ? RECOVER : IDLE;
                end
            end

            HELD: begin
                dev_rst_next = 1'b1;
                bsy_next     = 1'b1;
                if (l_sync && srst_clear) begin
                    state_next   = RECOVER;
                    cnt_next     = '0;
                    dev_rst_next = 1'b0;
                end
            end

            RECOVER: begin
                dev_rst_next = 1'b0;
                bsy_next     = 1'b1;
                if (!l_sync) begin
                    state_next    = QUALIFY;
                    cnt_next      = '0;
                    from_rec_next = 1'b1;
                end else if (rec_hit) begin
                    state_next    = IDLE;
                    cnt_next      = '0;
                    bsy_next      = 1'b0;
                    rst_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 21'd1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

`ifdef IDE_RESET_DETECTOR_SRST_EN
        // A soft reset skips qualification, but a simultaneous hardware accept takes priority.
        if (soft_edge && (state_reg != HELD) &&
            !((state_reg == QUALIFY) && !l_sync && qual_hit)) begin
            state_next     = HELD;
            cnt_next       = '0;
            dev_rst_next   = 1'b1;
            bsy_next       = 1'b1;
            rst_event_next = 1'b1;
            rst_done_next  = 1'b0;
            rst_soft_next  = 1'b1;
        end
`endif
    end

    assign bus.dev_rst    = dev_rst_reg;
    assign bus.rst_event  = rst_event_reg;
    assign bus.rst_done   = rst_done_reg;
    assign bus.bsy        = bsy_reg;
    assign bus.rst_soft   = rst_soft_reg;
    assign bus.glitch_cnt = glitch_cnt_reg;

endmodule
